vga_box_renderer: RTL and testbench
===================================

Name: vga_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA sync generator.
- Consumes the sync generator's pixel coordinates, video_on, pixel tick and hsync/vsync.
- Draws a fixed wall border and a bouncing square sprite, updating sprite position once per frame during vertical blanking.
- Emits registered 8-bit RGB (3:3:2) plus hsync/vsync delayed by the same one-pixel pipeline so colour and sync stay aligned at the connector.

Parameters:
HD, 640, horizontal display width in pixels
VD, 480, vertical display height in lines
BORDER, 8, wall thickness in pixels on all four edges
SIZE, 16, sprite edge length in pixels
STEP, 2, sprite displacement per frame on each axis
X0, 312, sprite left-edge x after reset
Y0, 232, sprite top-edge y after reset
BOX_COLOR, 8'hE0, sprite colour
WALL_COLOR, 8'hFF, border colour
BG_COLOR, 8'h03, background colour

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
p_tick  in  1  pixel enable from sync generator, high every second clk
video_on  in  1  high while pixel_x < HD and pixel_y < VD
pixel_x  in  10  current horizontal count 0..799
pixel_y  in  10  current vertical count 0..524
hsync_in  in  1  registered hsync from sync generator
vsync_in  in  1  registered vsync from sync generator
pause  in  1  synchronous level; when high, sprite motion is frozen
rgb  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}, registered
hsync  out  1  hsync_in delayed one pixel
vsync  out  1  vsync_in delayed one pixel
frame_cnt  out  8  frames elapsed since reset, wraps

Behaviour:
- Clock: clk. Reset: asynchronous, active-high, named reset.
- Reset values:
  - rgb=0, hsync=0, vsync=0, frame_cnt=0
  - box_x=X0, box_y=Y0
  - dir_x=right, dir_y=down
- All state updates are gated by p_tick. Clocks with p_tick=0 hold every register.
- Derived limits:
  - XMIN=BORDER, XMAX=HD-BORDER-SIZE (616)
  - YMIN=BORDER, YMAX=VD-BORDER-SIZE (456)
- frame_tick = p_tick && pixel_x==0 && pixel_y==VD.
  - Asserts exactly once per frame, at the first pixel of vertical blanking.
  - Position never changes while visible pixels are being drawn, so there is no tearing.
- On frame_tick:
  - frame_cnt increments; 255 wraps to 0. Increments regardless of pause.
  - If pause=0, each axis updates independently:
    - Moving right: if box_x+STEP >= XMAX, then box_x=XMAX and dir_x=left; else box_x += STEP.
    - Moving left: if box_x <= XMIN+STEP, then box_x=XMIN and dir_x=right; else box_x -= STEP.
    - Y axis: same rules with YMIN/YMAX, down/up.
  - If pause=1: box_x, box_y, dir_x and dir_y hold.
  - A simultaneous corner hit flips both directions in the same frame.
- Colour select (combinational, from current pixel_x/pixel_y), priority order:
  1. video_on=0 -> 8'h00
  2. wall: pixel_x < BORDER, pixel_x >= HD-BORDER, pixel_y < BORDER, or pixel_y >= VD-BORDER -> WALL_COLOR
  3. sprite: box_x <= pixel_x < box_x+SIZE and box_y <= pixel_y < box_y+SIZE -> BOX_COLOR
  4. otherwise -> BG_COLOR
- Output pipeline: on p_tick, rgb <= selected colour, hsync <= hsync_in, vsync <= vsync_in.
  - Latency: exactly one pixel (2 clk) from coordinate to rgb.
  - hsync/vsync skew relative to rgb is zero.
- Arithmetic: position registers are 10 bits unsigned. Comparisons use 11-bit intermediates so box_x+SIZE cannot overflow.
- Reset mid-frame: all state returns to reset values immediately. The next frame_tick performs the first move.
- Between frame_ticks the sprite never sits outside [XMIN,XMAX] x [YMIN,YMAX].

Test Plan:
1. Reset release, run to first frame_tick -> box_x 312->314, box_y 232->234, frame_cnt=1, dirs unchanged.
2. Run 112 frames from reset:
   - box_y reaches 456 and dir_y flips to up.
   - box_x=536.
   - Frame 113: box_y=454.
3. Run 152 frames from reset:
   - box_x=616 and dir_x flips to left.
   - Frame 153: box_x=614.
   - Continue until box_x=8, then dir_x flips to right.
4. Pixel colours after reset, each checked one p_tick after coordinate presentation:
   - (312,232) -> 8'hE0
   - (327,247) -> 8'hE0
   - (328,232) -> 8'h03
   - (3,100) -> 8'hFF
   - (100,475) -> 8'hFF
   - (700,10) -> 8'h00
   - In every case hsync/vsync equal the inputs delayed one p_tick.
5. Hold pause=1 across 10 frame_ticks -> box_x/box_y unchanged, frame_cnt +10. Release pause -> motion resumes with the prior direction.
6. Assert reset mid-frame after 50 frames -> immediate box_x=312, box_y=232, frame_cnt=0, rgb=0. Also run 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_box_renderer.sv
// Pixel stage after the VGA sync generator: fixed wall border plus a square sprite that bounces once per frame.
// Colour and syncs are registered together on p_tick, so both leave with exactly one pixel of latency.
module vga_box_renderer #(
    parameter int          HD         = 640,
    parameter int          VD         = 480,
    parameter int          BORDER     = 8,
    parameter int          SIZE       = 16,
    parameter int          STEP       = 2,
    parameter int          X0         = 312,
    parameter int          Y0         = 232,
    parameter logic [7:0]  BOX_COLOR  = 8'hE0,
    parameter logic [7:0]  WALL_COLOR = 8'hFF,
    parameter logic [7:0]  BG_COLOR   = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [7:0] rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] frame_cnt
);

    localparam logic [10:0] XMIN      = 11'(BORDER);
    localparam logic [10:0] XMAX      = 11'(HD - BORDER - SIZE);
    localparam logic [10:0] YMIN      = 11'(BORDER);
    localparam logic [10:0] YMAX      = 11'(VD - BORDER - SIZE);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] SIZE_W    = 11'(SIZE);
    localparam logic [10:0] BORDER_W  = 11'(BORDER);
    localparam logic [10:0] HD_WALL   = 11'(HD - BORDER);
    localparam logic [10:0] VD_WALL   = 11'(VD - BORDER);
    localparam logic [10:0] VD_W      = 11'(VD);

    logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;   // 1 = moving left
    logic        dir_y_q, dir_y_d;   // 1 = moving up
    logic [7:0]  rgb_q, rgb_d, frame_cnt_q, frame_cnt_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic [10:0] px, py, bx, by, x_next, y_next;
    logic        frame_tick, in_wall, in_box;
    logic [7:0]  color;

    // Returns {new_dir, new_pos}; hitting a limit clamps onto it and reverses.
    function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic neg,
                                              input logic [10:0] lo, input logic [10:0] hi);
        logic [10:0] p;
        p = {1'b0, pos};
        if (!neg) begin
            if (p + STEP_W >= hi) axis_next = {1'b1, hi[9:0]};
            else                  axis_next = {1'b0, 10'(p + STEP_W)};
        end else begin
            if (p <= lo + STEP_W) axis_next = {1'b0, lo[9:0]};
            else                  axis_next = {1'b1, 10'(p - STEP_W)};
        end
    endfunction

    assign px = {1'b0, pixel_x};
    assign py = {1'b0, pixel_y};
    assign bx = {1'b0, box_x_q};
    assign by = {1'b0, box_y_q};

    // First pixel of vertical blanking: moving here keeps the visible frame tear-free.
    assign frame_tick = p_tick && (px == 11'd0) && (py == VD_W);
    assign in_wall    = (px < BORDER_W) || (px >= HD_WALL) || (py < BORDER_W) || (py >= VD_WALL);
    assign in_box     = (px >= bx) && (px < bx + SIZE_W) && (py >= by) && (py < by + SIZE_W);
    assign x_next     = axis_next(box_x_q, dir_x_q, XMIN, XMAX);
    assign y_next     = axis_next(box_y_q, dir_y_q, YMIN, YMAX);

    always_comb begin
        color = BG_COLOR;
        if (!video_on)   color = 8'h00;
        else if (in_wall) color = WALL_COLOR;
        else if (in_box)  color = BOX_COLOR;
    end

    always_comb begin
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        rgb_d       = rgb_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        frame_cnt_d = frame_cnt_q;
        if (p_tick) begin
            rgb_d   = color;
            hsync_d = hsync_in;
            vsync_d = vsync_in;
        end
        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!pause) begin
                dir_x_d = x_next[10];
                box_x_d = x_next[9:0];
                dir_y_d = y_next[10];
                box_y_d = y_next[9:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x_q     <= 10'(X0);
            box_y_q     <= 10'(Y0);
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            rgb_q       <= 8'h00;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rgb       = rgb_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: plays the sync generator, presenting chosen coordinates one per pixel tick,
// and compares rgb/syncs/frame_cnt against a velocity-and-clamp model of the sprite.
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] rgb, frame_cnt;
    logic       hsync, vsync;

    int nvec = 0;
    int nmiss = 0;
    int mbx, mby, mvx, mvy, mfc;
    int ox[6] = '{0, 15, -1, 16, 0, 15};
    int oy[6] = '{0, 15, 0, 15, -1, 16};

    always #5 clk = ~clk;

    vga_box_renderer dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pause(pause), .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_cnt(frame_cnt)
    );

    task automatic model_reset();
        mbx = 312; mby = 232; mvx = 2; mvy = 2; mfc = 0;
    endtask

    task automatic model_frame(input logic pz);
        mfc = (mfc + 1) % 256;
        if (!pz) begin
            if (mvx > 0 && mbx + mvx >= 616)    begin mbx = 616; mvx = -2; end
            else if (mvx < 0 && mbx + mvx <= 8) begin mbx = 8;   mvx = 2;  end
            else mbx = mbx + mvx;
            if (mvy > 0 && mby + mvy >= 456)    begin mby = 456; mvy = -2; end
            else if (mvy < 0 && mby + mvy <= 8) begin mby = 8;   mvy = 2;  end
            else mby = mby + mvy;
        end
    endtask

    function automatic logic [7:0] exp_color(input int x, input int y);
        if (!(x < 640 && y < 480)) return 8'h00;
        if (x < 8 || x >= 632 || y < 8 || y >= 472) return 8'hFF;
        if (x >= mbx && x < mbx + 16 && y >= mby && y < mby + 16) return 8'hE0;
        return 8'h03;
    endfunction

    // One pixel: coordinates held with p_tick high for one clk, then a p_tick-low clk; sampled at the negedge in between.
    task automatic apply_px(input int x, input int y, input logic hs, input logic vs);
        @(negedge clk);
        pixel_x  = x[9:0];
        pixel_y  = y[9:0];
        video_on = (x < 640 && y < 480);
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clk);
        p_tick   = 1'b0;
    endtask

    task automatic run_frame(input logic pz);
        pause = pz;
        apply_px(0, 480, 1'b0, 1'b0);
        model_frame(pz);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        pixel_x = 10'd320; pixel_y = 10'd240; video_on = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1; p_tick = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (rgb !== 8'h00) begin nmiss++; $display("FAIL reset_rgb got %h want 00", rgb); end
        nvec++; if (hsync !== 1'b0) begin nmiss++; $display("FAIL reset_hsync got %b want 0", hsync); end
        nvec++; if (vsync !== 1'b0) begin nmiss++; $display("FAIL reset_vsync got %b want 0", vsync); end
        nvec++; if (frame_cnt !== 8'h00) begin nmiss++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        p_tick = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_pixels();
        int xs[6] = '{312, 327, 328, 3, 100, 700};
        int ys[6] = '{232, 247, 232, 100, 475, 10};
        logic [7:0] es[6] = '{8'hE0, 8'hE0, 8'h03, 8'hFF, 8'hFF, 8'h00};
        for (int k = 0; k < 6; k++) begin
            logic hs, vs;
            logic [7:0] held;
            hs = 1'($urandom); vs = 1'($urandom);
            apply_px(xs[k], ys[k], hs, vs);
            nvec++; if (rgb !== es[k]) begin nmiss++; $display("FAIL pixel_rgb (%0d,%0d) got %h want %h", xs[k], ys[k], rgb, es[k]); end
            nvec++; if (hsync !== hs) begin nmiss++; $display("FAIL pixel_hsync k=%0d got %b want %b", k, hsync, hs); end
            nvec++; if (vsync !== vs) begin nmiss++; $display("FAIL pixel_vsync k=%0d got %b want %b", k, vsync, vs); end
            held = rgb;
            // Without p_tick nothing may move, not even on the frame-tick coordinate.
            pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
            hsync_in = ~hs; vsync_in = ~vs;
            repeat (2) @(negedge clk);
            nvec++; if (rgb !== held || hsync !== hs || vsync !== vs) begin
                nmiss++; $display("FAIL hold_no_tick k=%0d rgb=%h hs=%b vs=%b want %h %b %b", k, rgb, hsync, vsync, held, hs, vs);
            end
            nvec++; if (frame_cnt !== 8'd0) begin nmiss++; $display("FAIL hold_frame_cnt got %0d want 0", frame_cnt); end
        end
    endtask

    task automatic test_first_frame();
        int xs[8] = '{314, 313, 314, 329, 330, 329, 316, 315};
        int ys[8] = '{234, 234, 233, 249, 249, 250, 236, 236};
        logic [7:0] es[8] = '{8'hE0, 8'h03, 8'h03, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'h03};
        run_frame(1'b0);
        nvec++; if (frame_cnt !== 8'd1) begin nmiss++; $display("FAIL first_frame_cnt got %0d want 1", frame_cnt); end
        for (int k = 0; k < 8; k++) begin
            if (k == 6) run_frame(1'b0);
            apply_px(xs[k], ys[k], 1'b0, 1'b0);
            nvec++; if (rgb !== es[k]) begin nmiss++; $display("FAIL first_frame_px (%0d,%0d) got %h want %h", xs[k], ys[k], rgb, es[k]); end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int f = 1; f <= 500; f++) begin
            run_frame(1'b0);
            nvec++; if (frame_cnt !== 8'(mfc)) begin nmiss++; $display("FAIL bounce_cnt f=%0d got %0d want %0d", f, frame_cnt, mfc); end
            for (int k = 0; k < 6; k++) begin
                int x, y;
                logic [7:0] e;
                x = mbx + ox[k]; y = mby + oy[k];
                e = exp_color(x, y);
                apply_px(x, y, 1'b0, 1'b0);
                nvec++; if (rgb !== e) begin nmiss++; $display("FAIL bounce_px f=%0d (%0d,%0d) got %h want %h", f, x, y, rgb, e); end
            end
            if (f == 112) begin
                apply_px(536, 456, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'hE0) begin nmiss++; $display("FAIL bottom_hit got %h want e0", rgb); end
                apply_px(536, 455, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'h03) begin nmiss++; $display("FAIL bottom_hit_above got %h want 03", rgb); end
            end
            if (f == 113) begin
                apply_px(538, 454, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'hE0) begin nmiss++; $display("FAIL bottom_rebound got %h want e0", rgb); end
                apply_px(538, 453, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'h03) begin nmiss++; $display("FAIL bottom_rebound_above got %h want 03", rgb); end
            end
            if (f == 152) begin
                apply_px(616, mby, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'hE0) begin nmiss++; $display("FAIL right_hit got %h want e0", rgb); end
                apply_px(615, mby, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'h03) begin nmiss++; $display("FAIL right_hit_left got %h want 03", rgb); end
            end
            if (f == 153) begin
                apply_px(614, mby, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'hE0) begin nmiss++; $display("FAIL right_rebound got %h want e0", rgb); end
                apply_px(630, mby, 1'b0, 1'b0);
                nvec++; if (rgb !== 8'h03) begin nmiss++; $display("FAIL right_rebound_edge got %h want 03", rgb); end
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int f = 1; f <= 100; f++) begin
            logic pz;
            if (f <= 20)      pz = 1'b0;
            else if (f <= 30) pz = 1'b1;
            else if (f <= 40) pz = 1'b0;
            else              pz = 1'($urandom_range(0, 1));
            run_frame(pz);
            nvec++; if (frame_cnt !== 8'(mfc)) begin nmiss++; $display("FAIL pause_cnt f=%0d got %0d want %0d", f, frame_cnt, mfc); end
            for (int k = 0; k < 6; k++) begin
                int x, y;
                logic [7:0] e;
                x = mbx + ox[k]; y = mby + oy[k];
                e = exp_color(x, y);
                apply_px(x, y, 1'b0, 1'b0);
                nvec++; if (rgb !== e) begin nmiss++; $display("FAIL pause_px f=%0d (%0d,%0d) got %h want %h", f, x, y, rgb, e); end
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_random_pixels();
        for (int n = 0; n < 300; n++) begin
            int x, y;
            logic hs, vs;
            logic [7:0] e;
            if (n % 2 == 0) begin
                x = $urandom_range(0, 799); y = $urandom_range(0, 524);
            end else begin
                x = mbx - 4 + $urandom_range(0, 23); y = mby - 4 + $urandom_range(0, 23);
            end
            if (x == 0 && y == 480) x = 1;
            hs = 1'($urandom); vs = 1'($urandom);
            e = exp_color(x, y);
            apply_px(x, y, hs, vs);
            nvec++; if (rgb !== e || hsync !== hs || vsync !== vs) begin
                nmiss++; $display("FAIL rand_px (%0d,%0d) got %h %b %b want %h %b %b", x, y, rgb, hsync, vsync, e, hs, vs);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (50) run_frame(1'b0);
        apply_px(mbx, mby, 1'b1, 1'b1);
        nvec++; if (rgb !== 8'hE0 || frame_cnt !== 8'd50) begin nmiss++; $display("FAIL pre_reset got %h cnt %0d want e0 50", rgb, frame_cnt); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        nvec++; if (rgb !== 8'h00 || hsync !== 1'b0 || vsync !== 1'b0) begin
            nmiss++; $display("FAIL mid_reset_out got %h %b %b want 00 0 0", rgb, hsync, vsync);
        end
        nvec++; if (frame_cnt !== 8'd0) begin nmiss++; $display("FAIL mid_reset_cnt got %0d want 0", frame_cnt); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply_px(312, 232, 1'b0, 1'b0);
        nvec++; if (rgb !== 8'hE0) begin nmiss++; $display("FAIL mid_reset_box got %h want e0", rgb); end
        apply_px(311, 232, 1'b0, 1'b0);
        nvec++; if (rgb !== 8'h03) begin nmiss++; $display("FAIL mid_reset_left got %h want 03", rgb); end
        run_frame(1'b0);
        apply_px(314, 234, 1'b0, 1'b0);
        nvec++; if (rgb !== 8'hE0 || frame_cnt !== 8'd1) begin nmiss++; $display("FAIL mid_reset_move got %h cnt %0d want e0 1", rgb, frame_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (255) run_frame(1'($urandom_range(0, 1)));
        nvec++; if (frame_cnt !== 8'd255) begin nmiss++; $display("FAIL wrap_255 got %0d want 255", frame_cnt); end
        run_frame(1'b0);
        nvec++; if (frame_cnt !== 8'd0) begin nmiss++; $display("FAIL wrap_0 got %0d want 0", frame_cnt); end
        apply_px(mbx + 7, mby + 7, 1'b0, 1'b0);
        nvec++; if (rgb !== exp_color(mbx + 7, mby + 7)) begin nmiss++; $display("FAIL wrap_box got %h want e0", rgb); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_first_frame();
        test_bounce();
        test_pause();
        test_random_pixels();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
